t_lut_sweep_counter: RTL and testbench

- Parametrised sweep counter for the temporal-LUT datapath. It generalises the plain enable-gated counter with a programmable terminal count, three run modes and a start/stop/done handshake.
- It also provides NUM_CH per-channel temporal (unary) pulse outputs, each high while the sweep count is below that channel's latched threshold.
- Sits between the LUT sequencer, which issues start/stop, and the per-channel temporal encoders.

---
 rtl/t_lut_sweep_counter.sv | 125 ++++++++++++
 tb/tb_t_lut_sweep_counter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/t_lut_sweep_counter.sv
// rtl/t_lut_sweep_counter.sv - temporal-LUT sweep counter with run modes and per-channel unary pulses
// Optional build macro: T_LUT_GRAY_OUT_EN (cnt_out carries registered Gray code of the count).
module t_lut_sweep_counter #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [WIDTH-1:0]        term_cnt,
  input  logic [NUM_CH*WIDTH-1:0] thr,
  output logic                    busy,
  output logic                    done,
  output logic                    wrap_pulse,
  output logic [WIDTH-1:0]        cnt_out,
  output logic [NUM_CH-1:0]       tpulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] M_WRAP = 2'd0;
  localparam logic [1:0] M_SAT  = 2'd2;

  state_t                    state;
  logic [WIDTH-1:0]          cnt;
  logic [WIDTH-1:0]          term_lat;
  logic [1:0]                mode_lat;
  logic [NUM_CH*WIDTH-1:0]   thr_lat;
  logic                      at_term;
  logic [WIDTH-1:0]          cnt_inc;

  // cnt_out is registered from the same next-count value as cnt so both move together.
  function automatic logic [WIDTH-1:0] out_enc(input logic [WIDTH-1:0] v);
`ifdef T_LUT_GRAY_OUT_EN
    return (v >> 1) ^ v;
`else
    return v;
`endif
  endfunction

  assign at_term = (cnt == term_lat);
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cnt_out    <= '0;
      term_lat   <= '0;
      mode_lat   <= '0;
      thr_lat    <= '0;
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        cnt     <= '0;
        cnt_out <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt     <= '0;
            cnt_out <= '0;
            if (start) begin
              mode_lat <= mode;
              term_lat <= term_cnt;
              thr_lat  <= thr;
              state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (enable) begin
              // Terminal compare comes first, so term_lat = all-ones never overflows.
              if (at_term) begin
                case (mode_lat)
                  M_WRAP: begin
                    cnt        <= '0;
                    cnt_out    <= '0;
                    wrap_pulse <= 1'b1;
                  end
                  M_SAT: begin
                    state <= S_HOLD;
                  end
                  default: begin
                    cnt     <= '0;
                    cnt_out <= '0;
                    state   <= S_IDLE;
                    done    <= 1'b1;
                  end
                endcase
              end else begin
                cnt     <= cnt_inc;
                cnt_out <= out_enc(cnt_inc);
              end
            end
          end
          S_HOLD: begin
            state <= S_HOLD;
          end
          default: begin
            state   <= S_IDLE;
            cnt     <= '0;
            cnt_out <= '0;
          end
        endcase
      end
    end
  end

  assign busy = (state == S_RUN) || (state == S_HOLD);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_tpulse
    assign tpulse[i] = busy && (cnt < thr_lat[i*WIDTH +: WIDTH]);
  end

endmodule

// File: tb/tb_t_lut_sweep_counter.sv
// tb/tb_t_lut_sweep_counter.sv - scoreboard bench for t_lut_sweep_counter
module tb_t_lut_sweep_counter;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    enable = 1'b0;
  logic                    start = 1'b0;
  logic                    stop = 1'b0;
  logic [1:0]              mode = 2'd0;
  logic [WIDTH-1:0]        term_cnt = '0;
  logic [NUM_CH*WIDTH-1:0] thr = '0;
  logic                    busy;
  logic                    done;
  logic                    wrap_pulse;
  logic [WIDTH-1:0]        cnt_out;
  logic [NUM_CH-1:0]       tpulse;

  t_lut_sweep_counter #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .term_cnt(term_cnt), .thr(thr), .busy(busy), .done(done),
    .wrap_pulse(wrap_pulse), .cnt_out(cnt_out), .tpulse(tpulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] tb_enc(input logic [WIDTH-1:0] v);
`ifdef T_LUT_GRAY_OUT_EN
    return (v >> 1) ^ v;
`else
    return v;
`endif
  endfunction

  // Reference model: 0=IDLE 1=RUN 2=HOLD
  int               m_st;
  logic [WIDTH-1:0] m_cnt, m_term;
  logic [1:0]       m_mode;
  logic [NUM_CH*WIDTH-1:0] m_thr;
  logic             m_done, m_wrap;

  typedef struct {
    logic             busy;
    logic             done;
    logic             wrap;
    logic [WIDTH-1:0] cnt_out;
    logic [NUM_CH-1:0] tp;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    m_st = 0; m_cnt = '0; m_term = '0; m_mode = '0; m_thr = '0; m_done = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    m_done = 0; m_wrap = 0;
    if (stop) begin
      m_st = 0; m_cnt = '0;
    end else if (m_st == 0) begin
      m_cnt = '0;
      if (start) begin
        m_st = 1; m_mode = mode; m_term = term_cnt; m_thr = thr;
      end
    end else if (m_st == 1 && enable) begin
      if (m_cnt != m_term) m_cnt = m_cnt + 1'b1;
      else if (m_mode == 2'd0) begin m_cnt = '0; m_wrap = 1; end
      else if (m_mode == 2'd2) m_st = 2;
      else begin m_cnt = '0; m_st = 0; m_done = 1; end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.busy = (m_st != 0);
    e.done = m_done;
    e.wrap = m_wrap;
    e.cnt_out = tb_enc(m_cnt);
    for (int i = 0; i < NUM_CH; i++)
      e.tp[i] = e.busy && (m_cnt < m_thr[i*WIDTH +: WIDTH]);
    sb.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
    push_exp();
  end

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("busy", 32'(busy), 32'(e.busy));
      check("done", 32'(done), 32'(e.done));
      check("wrap_pulse", 32'(wrap_pulse), 32'(e.wrap));
      check("cnt_out", 32'(cnt_out), 32'(e.cnt_out));
      check("tpulse", 32'(tpulse), 32'(e.tp));
    end
  end

  // Event tallies for whole-sweep properties.
  int n_tp0, n_tp1, n_done, n_wrap, n_done_busy;
  always @(negedge clk) begin
    if (tpulse[0]) n_tp0++;
    if (tpulse[1]) n_tp1++;
    if (done) n_done++;
    if (wrap_pulse) n_wrap++;
    if (done && busy) n_done_busy++;
  end

  task automatic clr_tally();
    #1;
    n_tp0 = 0; n_tp1 = 0; n_done = 0; n_wrap = 0; n_done_busy = 0;
  endtask

  task automatic drive(input logic en, input logic st, input logic sp);
    enable = en; start = st; stop = sp;
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] md, input logic [WIDTH-1:0] tc, input logic [NUM_CH*WIDTH-1:0] th);
    mode = md; term_cnt = tc; thr = th;
  endtask

  logic [7:0]       en_pat;
  logic [WIDTH-1:0] gray_tab [8];

  initial begin
    // Reset with start and enable held high.
    start = 1; enable = 1; cfg(2'd1, 8'd3, {8'd9, 8'd9, 8'd9, 8'd9});
    repeat (4) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt_out", 32'(cnt_out), 0);
    rst_n = 1; start = 0;
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("post_rst_idle", 32'(busy), 0);

    // ONESHOT term=5, ch0=3, ch1=0.
    clr_tally();
    cfg(2'd1, 8'd5, {8'd5, 8'd10, 8'd0, 8'd3});
    drive(1, 1, 0);
    check("t2_run_next", 32'(busy), 1);
    repeat (8) drive(1, 0, 0);
    #1;
    check("t2_tp0_cycles", n_tp0, 3);
    check("t2_tp1_cycles", n_tp1, 0);
    check("t2_done_count", n_done, 1);
    check("t2_done_busy", n_done_busy, 0);

    // WRAP term=3, ten enabled cycles then stop.
    clr_tally();
    cfg(2'd0, 8'd3, {8'd1, 8'd2, 8'd3, 8'd4});
    drive(1, 1, 0);
    repeat (9) drive(1, 0, 0);
    drive(1, 0, 1);
    check("t3_stop_idle", 32'(busy), 0);
    drive(0, 0, 0);
    #1;
    check("t3_wrap_count", n_wrap, 2);
    check("t3_no_done", n_done, 0);

    // ONESHOT term=4 with gapped enable and a mid-run start carrying a new term.
    clr_tally();
    cfg(2'd1, 8'd4, {8'd2, 8'd2, 8'd2, 8'd2});
    en_pat = 8'b1101_1001;
    drive(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        term_cnt = 8'd1;
        drive(en_pat[i], 1, 0);
      end else begin
        drive(en_pat[i], 0, 0);
      end
    end
    drive(0, 0, 0);
    drive(0, 0, 0);
    #1;
    check("t4_done_count", n_done, 1);

    // SATURATE term=255, thr ch0=255.
    cfg(2'd2, 8'd255, {8'd0, 8'd0, 8'd128, 8'd255});
    drive(1, 1, 0);
    repeat (258) drive(1, 0, 0);
    for (int i = 0; i < 6; i++) drive(i[0], 0, 0);
    check("t5_hold_busy", 32'(busy), 1);
    check("t5_hold_cnt", 32'(cnt_out), 32'(tb_enc(8'd255)));
    check("t5_hold_tp0", 32'(tpulse[0]), 0);
    drive(1, 0, 1);
    check("t5_stop_idle", 32'(busy), 0);

    // Stop coinciding with ONESHOT terminal count.
    clr_tally();
    cfg(2'd3, 8'd2, {8'd1, 8'd1, 8'd1, 8'd1});
    drive(1, 1, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 1);
    drive(1, 0, 0);
    #1;
    check("t6_stop_no_done", n_done, 0);

    // term=0 in WRAP and ONESHOT.
    clr_tally();
    cfg(2'd0, 8'd0, {8'd1, 8'd0, 8'd1, 8'd1});
    drive(1, 1, 0);
    repeat (4) drive(1, 0, 0);
    drive(0, 0, 1);
    cfg(2'd1, 8'd0, {8'd1, 8'd0, 8'd1, 8'd1});
    drive(0, 1, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    #1;
    check("t0_wrap_count", n_wrap, 4);
    check("t0_done_count", n_done, 1);

    // Output encoding over 0..7.
    gray_tab[0] = 8'd0; gray_tab[1] = 8'd1; gray_tab[2] = 8'd3; gray_tab[3] = 8'd2;
    gray_tab[4] = 8'd6; gray_tab[5] = 8'd7; gray_tab[6] = 8'd5; gray_tab[7] = 8'd4;
    cfg(2'd0, 8'd7, {8'd4, 8'd4, 8'd4, 8'd4});
    drive(1, 1, 0);
    for (int i = 0; i < 8; i++) begin
`ifdef T_LUT_GRAY_OUT_EN
      check("gray_seq", 32'(cnt_out), 32'(gray_tab[i]));
`else
      check("bin_seq", 32'(cnt_out), i);
`endif
      drive(1, 0, 0);
    end
    drive(0, 0, 1);

    // Asynchronous reset mid-sweep at cnt=2.
    clr_tally();
    cfg(2'd1, 8'd10, {8'd5, 8'd5, 8'd5, 8'd5});
    drive(1, 1, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("t6_cnt_before_rst", 32'(cnt_out), 32'(tb_enc(8'd2)));
    #2 rst_n = 0;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_cnt", 32'(cnt_out), 0);
    check("t6_rst_tpulse", 32'(tpulse), 0);
    check("t6_rst_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    drive(1, 0, 0);
    drive(1, 0, 0);
    #1;
    check("t6_rst_no_done", n_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
